// File: rtl/tri_bbox_scanner_if.sv
// Triangle-in / sample-out bundle between the set-up stage, tri_bbox_scanner and
// the barycentric interpolator. Vertex buses pack vertex i at [i*WIDTH +: WIDTH].
interface tri_bbox_scanner_if #(
   parameter int XWIDTH     = 16,
   parameter int YWIDTH     = 16,
   parameter int AINV_WIDTH = 16
);
   logic                    tri_valid_in;
   logic                    tri_ready_out;
   logic [3*XWIDTH-1:0]     x_tri_in;
   logic [3*YWIDTH-1:0]     y_tri_in;
   logic [AINV_WIDTH-1:0]   iarea_in;
   logic [XWIDTH-1:0]       x_out;
   logic [YWIDTH-1:0]       y_out;
   logic [3*XWIDTH-1:0]     x_tri_out;
   logic [3*YWIDTH-1:0]     y_tri_out;
   logic [AINV_WIDTH-1:0]   iarea_out;
   logic                    valid_out;
   logic                    last_out;
   logic                    done_out;

   modport slave (
      input  tri_valid_in, x_tri_in, y_tri_in, iarea_in,
      output tri_ready_out, x_out, y_out, x_tri_out, y_tri_out, iarea_out,
             valid_out, last_out, done_out
   );

   modport master (
      output tri_valid_in, x_tri_in, y_tri_in, iarea_in,
      input  tri_ready_out, x_out, y_out, x_tri_out, y_tri_out, iarea_out,
             valid_out, last_out, done_out
   );
endinterface

// File: rtl/tri_bbox_scanner.sv
// Bounding-box pixel walker feeding the barycentric interpolator, one pixel-centre
// sample per unfrozen cycle. Define BBOX_SCREEN_CLIP_EN to clip the box to the screen.
//
// state | meaning
// IDLE  | waiting for a triangle; ready unless frozen
// SETUP | box derived from latched vertices, counters loaded
// SCAN  | one sample per cycle; also retires empty boxes and the cycle after last
module tri_bbox_scanner #(
   parameter int XWIDTH     = 16,
   parameter int YWIDTH     = 16,
   parameter int FRAC       = 4,
   parameter int AINV_WIDTH = 16,
   parameter int HRES       = 320,
   parameter int VRES       = 240
) (
   input  logic clk_in,
   input  logic rst_n_in,
   input  logic freeze,
   tri_bbox_scanner_if.slave tri_if
);
   localparam int CXW = XWIDTH - FRAC + 1;
   localparam int CYW = YWIDTH - FRAC + 1;
   localparam logic [FRAC-1:0] HALF = FRAC'(1 << (FRAC - 1));

   if (FRAC < 1 || CXW < 2 || CYW < 2 || HRES < 1 || VRES < 1) begin : g_bad_cfg
      $error("tri_bbox_scanner: invalid parameter set");
   end

   typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, SCAN = 2'd2} state_t;

   state_t                  state_q, state_d;
   logic signed [CXW-1:0]   px_q, px_d, xmin_q, xmin_d, xmax_q, xmax_d;
   logic signed [CYW-1:0]   py_q, py_d, ymax_q, ymax_d;
   logic                    empty_q, empty_d;
   logic [XWIDTH-1:0]       x_out_q, x_out_d;
   logic [YWIDTH-1:0]       y_out_q, y_out_d;
   logic [3*XWIDTH-1:0]     x_tri_q, x_tri_d;
   logic [3*YWIDTH-1:0]     y_tri_q, y_tri_d;
   logic [AINV_WIDTH-1:0]   iarea_q, iarea_d;
   logic                    valid_q, valid_d;
   logic                    last_q, last_d;
   logic                    done_q, done_d;

   logic signed [XWIDTH-1:0] xlo, xhi;
   logic signed [YWIDTH-1:0] ylo, yhi;
   logic signed [CXW-1:0]    bx_min, bx_max;
   logic signed [CYW-1:0]    by_min, by_max;
   logic                     box_empty;
   logic                     at_end;

`ifdef BBOX_SCREEN_CLIP_EN
   localparam logic signed [CXW-1:0] X_LIM = CXW'(HRES - 1);
   localparam logic signed [CYW-1:0] Y_LIM = CYW'(VRES - 1);
`endif

   // Box from the latched vertices; >>> on signed values floors toward -inf.
   always_comb begin
      xlo = $signed(x_tri_q[XWIDTH-1:0]);
      xhi = xlo;
      ylo = $signed(y_tri_q[YWIDTH-1:0]);
      yhi = ylo;
      for (int i = 1; i < 3; i++) begin
         if ($signed(x_tri_q[i*XWIDTH +: XWIDTH]) < xlo) xlo = $signed(x_tri_q[i*XWIDTH +: XWIDTH]);
         if ($signed(x_tri_q[i*XWIDTH +: XWIDTH]) > xhi) xhi = $signed(x_tri_q[i*XWIDTH +: XWIDTH]);
         if ($signed(y_tri_q[i*YWIDTH +: YWIDTH]) < ylo) ylo = $signed(y_tri_q[i*YWIDTH +: YWIDTH]);
         if ($signed(y_tri_q[i*YWIDTH +: YWIDTH]) > yhi) yhi = $signed(y_tri_q[i*YWIDTH +: YWIDTH]);
      end
      bx_min = CXW'(xlo >>> FRAC);
      bx_max = CXW'(xhi >>> FRAC);
      by_min = CYW'(ylo >>> FRAC);
      by_max = CYW'(yhi >>> FRAC);
`ifdef BBOX_SCREEN_CLIP_EN
      if (bx_min < 0)     bx_min = '0;
      if (bx_max > X_LIM) bx_max = X_LIM;
      if (by_min < 0)     by_min = '0;
      if (by_max > Y_LIM) by_max = Y_LIM;
`endif
      box_empty = (bx_min > bx_max) || (by_min > by_max);
   end

   assign at_end = (px_q == xmax_q) && (py_q == ymax_q);

   always_comb begin
      state_d = state_q;
      px_d    = px_q;
      py_d    = py_q;
      xmin_d  = xmin_q;
      xmax_d  = xmax_q;
      ymax_d  = ymax_q;
      empty_d = empty_q;
      x_out_d = x_out_q;
      y_out_d = y_out_q;
      x_tri_d = x_tri_q;
      y_tri_d = y_tri_q;
      iarea_d = iarea_q;
      valid_d = valid_q;
      last_d  = last_q;
      done_d  = done_q;
      if (!freeze) begin
         case (state_q)
            IDLE: begin
               valid_d = 1'b0;
               last_d  = 1'b0;
               done_d  = 1'b0;
               if (tri_if.tri_valid_in) begin
                  x_tri_d = tri_if.x_tri_in;
                  y_tri_d = tri_if.y_tri_in;
                  iarea_d = tri_if.iarea_in;
                  state_d = SETUP;
               end
            end
            SETUP: begin
               px_d    = bx_min;
               py_d    = by_min;
               xmin_d  = bx_min;
               xmax_d  = bx_max;
               ymax_d  = by_max;
               empty_d = box_empty;
               state_d = SCAN;
            end
            SCAN: begin
               if (empty_q) begin
                  done_d  = 1'b1;
                  state_d = IDLE;
               end else if (last_q) begin
                  // Final sample has been shown for its cycle; ready rises next.
                  valid_d = 1'b0;
                  last_d  = 1'b0;
                  done_d  = 1'b0;
                  state_d = IDLE;
               end else begin
                  x_out_d = {px_q[XWIDTH-FRAC-1:0], HALF};
                  y_out_d = {py_q[YWIDTH-FRAC-1:0], HALF};
                  valid_d = 1'b1;
                  last_d  = at_end;
                  done_d  = at_end;
                  if (!at_end) begin
                     if (px_q == xmax_q) begin
                        px_d = xmin_q;
                        py_d = py_q + CYW'(1);
                     end else begin
                        px_d = px_q + CXW'(1);
                     end
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q <= IDLE;
         px_q    <= '0;
         py_q    <= '0;
         xmin_q  <= '0;
         xmax_q  <= '0;
         ymax_q  <= '0;
         empty_q <= 1'b0;
         x_out_q <= '0;
         y_out_q <= '0;
         x_tri_q <= '0;
         y_tri_q <= '0;
         iarea_q <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         px_q    <= px_d;
         py_q    <= py_d;
         xmin_q  <= xmin_d;
         xmax_q  <= xmax_d;
         ymax_q  <= ymax_d;
         empty_q <= empty_d;
         x_out_q <= x_out_d;
         y_out_q <= y_out_d;
         x_tri_q <= x_tri_d;
         y_tri_q <= y_tri_d;
         iarea_q <= iarea_d;
         valid_q <= valid_d;
         last_q  <= last_d;
         done_q  <= done_d;
      end
   end

   assign tri_if.tri_ready_out = (state_q == IDLE) && !freeze;
   assign tri_if.x_out         = x_out_q;
   assign tri_if.y_out         = y_out_q;
   assign tri_if.x_tri_out     = x_tri_q;
   assign tri_if.y_tri_out     = y_tri_q;
   assign tri_if.iarea_out     = iarea_q;
   assign tri_if.valid_out     = valid_q;
   assign tri_if.last_out      = last_q;
   assign tri_if.done_out      = done_q;
endmodule

// File: tb/tb_tri_bbox_scanner.sv
// Directed bench for tri_bbox_scanner: nominal scan, freeze, degenerate, off-screen,
// back-to-back and mid-scan reset. Coordinates are 12.4 fixed point.
module tb_tri_bbox_scanner;
   logic clk = 1'b0;
   logic rst_n;
   logic freeze;
   int   total = 0;
   int   bad   = 0;

   tri_bbox_scanner_if #(.XWIDTH(16), .YWIDTH(16), .AINV_WIDTH(16)) bus ();

   tri_bbox_scanner #(
      .XWIDTH(16), .YWIDTH(16), .FRAC(4), .AINV_WIDTH(16), .HRES(320), .VRES(240)
   ) dut (
      .clk_in   (clk),
      .rst_n_in (rst_n),
      .freeze   (freeze),
      .tri_if   (bus)
   );

   always #5 clk = ~clk;

   // (2.3,1.1),(4.9,1.5),(3.0,2.8) -> x raw 36,78,48  y raw 17,24,44
   localparam logic [47:0] T1X = {16'd48, 16'd78, 16'd36};
   localparam logic [47:0] T1Y = {16'd44, 16'd24, 16'd17};
   // (7.2,7.2) x3 -> raw 115
   localparam logic [47:0] DGX = {16'd115, 16'd115, 16'd115};
   // x = -3,-1,-5 ; y = 1.0
   localparam logic [47:0] NGX = {16'hFFD0, 16'hFFF0, 16'hFFB0};
   localparam logic [47:0] NGY = {16'd16, 16'd16, 16'd16};

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Offer a triangle at a negedge where ready is expected; returns at the negedge
   // after accept+2, when the first sample (or empty done) is visible.
   task automatic send(input logic [47:0] xt, input logic [47:0] yt, input logic [15:0] ia);
      chk("ready_before_accept", bus.tri_ready_out, 1'b1);
      bus.tri_valid_in = 1'b1;
      bus.x_tri_in     = xt;
      bus.y_tri_in     = yt;
      bus.iarea_in     = ia;
      @(negedge clk);
      bus.tri_valid_in = 1'b0;
      chk("latched_x_tri", bus.x_tri_out, xt);
      chk("latched_y_tri", bus.y_tri_out, yt);
      chk("latched_iarea", bus.iarea_out, ia);
      chk("ready_low_setup", bus.tri_ready_out, 1'b0);
      chk("valid_low_setup", bus.valid_out, 1'b0);
      @(negedge clk);
      chk("valid_low_preload", bus.valid_out, 1'b0);
      @(negedge clk);
   endtask

   // Walk the expected raster over a hand-computed box; frz_at >= 0 freezes for
   // three cycles while that sample index is showing.
   task automatic scan(input int xmin, input int xmax, input int ymin, input int ymax,
                       input int frz_at, input logic [47:0] xt);
      int idx = 0;
      int nsamp = (xmax - xmin + 1) * (ymax - ymin + 1);
      for (int py = ymin; py <= ymax; py++) begin
         for (int px = xmin; px <= xmax; px++) begin
            logic [15:0] ex = 16'(px * 16 + 8);
            logic [15:0] ey = 16'(py * 16 + 8);
            logic        lst = (idx == nsamp - 1);
            chk("sample_valid", bus.valid_out, 1'b1);
            chk("sample_x", bus.x_out, ex);
            chk("sample_y", bus.y_out, ey);
            chk("sample_last", bus.last_out, lst);
            chk("sample_done", bus.done_out, lst);
            chk("ready_busy", bus.tri_ready_out, 1'b0);
            chk("tri_stable", bus.x_tri_out, xt);
            if (idx == frz_at) begin
               freeze = 1'b1;
               repeat (3) begin
                  @(negedge clk);
                  chk("frz_x_hold", bus.x_out, ex);
                  chk("frz_y_hold", bus.y_out, ey);
                  chk("frz_valid_hold", bus.valid_out, 1'b1);
                  chk("frz_last_hold", bus.last_out, lst);
               end
               freeze = 1'b0;
            end
            @(negedge clk);
            idx++;
         end
      end
      chk("ready_after_scan", bus.tri_ready_out, 1'b1);
      chk("valid_after_scan", bus.valid_out, 1'b0);
      chk("done_after_scan", bus.done_out, 1'b0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n            = 1'b1;
      freeze           = 1'b0;
      bus.tri_valid_in = 1'b0;
      bus.x_tri_in     = '0;
      bus.y_tri_in     = '0;
      bus.iarea_in     = '0;
      #2 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_x_out", bus.x_out, 16'h0);
      chk("rst_y_out", bus.y_out, 16'h0);
      chk("rst_x_tri", bus.x_tri_out, 48'h0);
      chk("rst_y_tri", bus.y_tri_out, 48'h0);
      chk("rst_iarea", bus.iarea_out, 16'h0);
      chk("rst_valid", bus.valid_out, 1'b0);
      chk("rst_last", bus.last_out, 1'b0);
      chk("rst_done", bus.done_out, 1'b0);
      chk("rst_ready", bus.tri_ready_out, 1'b1);
      rst_n = 1'b1;
      @(negedge clk);

      // Nominal triangle: box x 2..4, y 1..2
      send(T1X, T1Y, 16'h1234);
      scan(2, 4, 1, 2, -1, T1X);

      // Same triangle, 3-cycle freeze while (4.5,1.5) is showing
      send(T1X, T1Y, 16'h5678);
      scan(2, 4, 1, 2, 2, T1X);

      // Degenerate: single sample (7.5,7.5) with valid/last/done together
      send(DGX, DGX, 16'h0ABC);
      scan(7, 7, 7, 7, -1, DGX);

      // Back-to-back with tri_valid_in held high
      bus.tri_valid_in = 1'b1;
      bus.x_tri_in     = DGX;
      bus.y_tri_in     = DGX;
      bus.iarea_in     = 16'h1111;
      @(negedge clk);
      bus.x_tri_in = T1X;
      bus.y_tri_in = T1Y;
      bus.iarea_in = 16'h2222;
      chk("b2b_first_latched", bus.x_tri_out, DGX);
      @(negedge clk);
      @(negedge clk);
      chk("b2b_first_last", bus.last_out, 1'b1);
      chk("b2b_no_ready_on_last", bus.tri_ready_out, 1'b0);
      chk("b2b_hold_before_accept", bus.x_tri_out, DGX);
      @(negedge clk);
      chk("b2b_ready_after_last", bus.tri_ready_out, 1'b1);
      chk("b2b_still_first", bus.iarea_out, 16'h1111);
      @(negedge clk);
      bus.tri_valid_in = 1'b0;
      chk("b2b_second_latched", bus.x_tri_out, T1X);
      chk("b2b_second_iarea", bus.iarea_out, 16'h2222);
      chk("b2b_ready_low", bus.tri_ready_out, 1'b0);
      @(negedge clk);
      @(negedge clk);
      scan(2, 4, 1, 2, -1, T1X);

      // Mid-scan asynchronous reset
      send(T1X, T1Y, 16'h3333);
      chk("pre_rst_sample_x", bus.x_out, 16'd40);
      @(negedge clk);
      chk("pre_rst_sample2_x", bus.x_out, 16'd56);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_x_out", bus.x_out, 16'h0);
      chk("arst_y_out", bus.y_out, 16'h0);
      chk("arst_x_tri", bus.x_tri_out, 48'h0);
      chk("arst_iarea", bus.iarea_out, 16'h0);
      chk("arst_valid", bus.valid_out, 1'b0);
      chk("arst_ready", bus.tri_ready_out, 1'b1);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Off-screen-left triangle: x -5..-1, y 1
      send(NGX, NGY, 16'h4444);
`ifdef BBOX_SCREEN_CLIP_EN
      chk("clip_done", bus.done_out, 1'b1);
      chk("clip_no_valid", bus.valid_out, 1'b0);
      chk("clip_ready", bus.tri_ready_out, 1'b1);
      @(negedge clk);
      chk("clip_done_cleared", bus.done_out, 1'b0);
`else
      scan(-5, -1, 1, 1, -1, NGX);
`endif

      freeze = 1'b1;
      #1;
      chk("ready_frozen_idle", bus.tri_ready_out, 1'b0);
      freeze = 1'b0;
      #1;
      chk("ready_unfrozen_idle", bus.tri_ready_out, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
